// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU, the result FIFO and its consumer.
// The FIFO sits on the slave modport; the bench drives the master side.
interface alu_result_fifo_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SEL_W  = 4,
    parameter int unsigned DEPTH  = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         alu_out;
    logic                      carry_out;
    logic [SEL_W-1:0]          alu_sel;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_carry;
    logic                      out_zero;
    logic                      out_neg;
    logic [$clog2(DEPTH):0]    count;
    logic                      drop_err;

    modport slave (
        input  in_valid, alu_out, carry_out, alu_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_carry,
               out_zero, out_neg, count, drop_err
    );

    modport master (
        output in_valid, alu_out, carry_out, alu_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_carry,
               out_zero, out_neg, count, drop_err
    );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through buffer for ALU results; derives zero/negative
// flags at capture and keeps a sticky drop diagnostic.
module alu_result_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SEL_W  = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_result_fifo_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
        logic              carry;
        logic              zero;
        logic              neg;
    } entry_t;

    entry_t            r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_drop_err;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    entry_t            w_new;
    entry_t            w_head;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && !w_full;
    assign w_pop   = !w_empty && bus.out_ready;

    always_comb begin
        w_new       = '0;
        w_new.data  = bus.alu_out;
        w_new.sel   = bus.alu_sel;
        w_new.carry = bus.carry_out;
        w_new.zero  = (bus.alu_out == '0);
        w_new.neg   = bus.alu_out[DATA_W-1];
    end

    // Storage is deliberately left out of reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (bus.in_valid && w_full) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_head = '0;
        if (!w_empty) begin
            w_head = r_mem[r_rd_ptr];
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_head.data;
    assign bus.out_sel   = w_head.sel;
    assign bus.out_carry = w_head.carry;
    assign bus.out_zero  = w_head.zero;
    assign bus.out_neg   = w_head.neg;
    assign bus.count     = r_count;
    assign bus.drop_err  = r_drop_err;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed vector table, hand-written wrap and
// async-reset sequences, then random traffic against a queue-based model.
module tb_alu_result_fifo;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned DEPTH  = 4;

    logic clk;
    logic rst_n;

    alu_result_fifo_if #(.DATA_W(DATA_W), .SEL_W(SEL_W), .DEPTH(DEPTH)) bus ();

    alu_result_fifo #(.DATA_W(DATA_W), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  sel;
        logic        carry;
    } mentry_t;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        c;
        logic [3:0]  s;
        logic        r;
        logic        e_valid;
        logic [15:0] e_data;
        logic [3:0]  e_sel;
        logic        e_carry;
        logic        e_zero;
        logic        e_neg;
        logic [2:0]  e_count;
        logic        e_ready;
        logic        e_drop;
    } vec_t;

    mentry_t model_q[$];
    logic    model_drop;
    int      n_checks = 0;
    int      n_pass   = 0;
    vec_t    vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        mentry_t h;
        logic    ne;
        ne = (model_q.size() != 0);
        h  = '{data: '0, sel: '0, carry: 1'b0};
        if (ne) h = model_q[0];
        check("m_out_valid", 32'(bus.out_valid), 32'(ne));
        check("m_in_ready",  32'(bus.in_ready),  32'(model_q.size() != DEPTH));
        check("m_count",     32'(bus.count),     32'(model_q.size()));
        check("m_out_data",  32'(bus.out_data),  32'(h.data));
        check("m_out_sel",   32'(bus.out_sel),   32'(h.sel));
        check("m_out_carry", 32'(bus.out_carry), 32'(h.carry));
        check("m_out_zero",  32'(bus.out_zero),  32'(ne && h.data == 16'h0000));
        check("m_out_neg",   32'(bus.out_neg),   32'(ne && h.data >= 16'h8000));
        check("m_drop_err",  32'(bus.drop_err),  32'(model_drop));
    endtask

    // Drives one cycle of stimulus, advances the model across the edge,
    // then compares 1 time unit after the edge.
    task automatic apply_cycle(input logic v, input logic [15:0] d, input logic c,
                               input logic [3:0] s, input logic r);
        bit m_push;
        bit m_pop;
        bus.in_valid  = v;
        bus.alu_out   = d;
        bus.carry_out = c;
        bus.alu_sel   = s;
        bus.out_ready = r;
        m_pop  = (model_q.size() != 0) && r;
        m_push = v && (model_q.size() != DEPTH);
        if (v && model_q.size() == DEPTH) model_drop = 1'b1;
        @(posedge clk);
        if (m_pop) void'(model_q.pop_front());
        if (m_push) model_q.push_back('{data: d, sel: s, carry: c});
        #1;
        compare_model();
    endtask

    function automatic vec_t mk(input logic v, input logic [15:0] d, input logic c,
                                input logic [3:0] s, input logic r, input logic ev,
                                input logic [15:0] ed, input logic [3:0] es, input logic ec,
                                input logic ez, input logic en, input logic [2:0] ecnt,
                                input logic erdy, input logic edrop);
        vec_t t;
        t.v = v; t.d = d; t.c = c; t.s = s; t.r = r;
        t.e_valid = ev; t.e_data = ed; t.e_sel = es; t.e_carry = ec;
        t.e_zero = ez; t.e_neg = en; t.e_count = ecnt; t.e_ready = erdy; t.e_drop = edrop;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_out   = '0;
        bus.carry_out = 1'b0;
        bus.alu_sel   = '0;
        bus.out_ready = 1'b0;
        model_drop    = 1'b0;

        // Single push/pop
        vecs.push_back(mk(1, 16'h0D78, 0, 4'h1, 0,  1, 16'h0D78, 4'h1, 0, 0, 0, 3'd1, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 4'h0, 1,  0, 16'h0000, 4'h0, 0, 0, 0, 3'd0, 1, 0));
        // Flags, in push order
        vecs.push_back(mk(1, 16'h0000, 1, 4'h2, 0,  1, 16'h0000, 4'h2, 1, 1, 0, 3'd1, 1, 0));
        vecs.push_back(mk(1, 16'hF623, 0, 4'h3, 0,  1, 16'h0000, 4'h2, 1, 1, 0, 3'd2, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 4'h0, 1,  1, 16'hF623, 4'h3, 0, 0, 1, 3'd1, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 4'h0, 1,  0, 16'h0000, 4'h0, 0, 0, 0, 3'd0, 1, 0));
        // Fill and overflow
        vecs.push_back(mk(1, 16'h0001, 0, 4'h4, 0,  1, 16'h0001, 4'h4, 0, 0, 0, 3'd1, 1, 0));
        vecs.push_back(mk(1, 16'h0002, 0, 4'h4, 0,  1, 16'h0001, 4'h4, 0, 0, 0, 3'd2, 1, 0));
        vecs.push_back(mk(1, 16'h0003, 0, 4'h4, 0,  1, 16'h0001, 4'h4, 0, 0, 0, 3'd3, 1, 0));
        vecs.push_back(mk(1, 16'h0004, 0, 4'h4, 0,  1, 16'h0001, 4'h4, 0, 0, 0, 3'd4, 0, 0));
        vecs.push_back(mk(1, 16'h0005, 0, 4'h4, 0,  1, 16'h0001, 4'h4, 0, 0, 0, 3'd4, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 4'h0, 1,  1, 16'h0002, 4'h4, 0, 0, 0, 3'd3, 1, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 4'h0, 1,  1, 16'h0003, 4'h4, 0, 0, 0, 3'd2, 1, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 4'h0, 1,  1, 16'h0004, 4'h4, 0, 0, 0, 3'd1, 1, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 4'h0, 1,  0, 16'h0000, 4'h0, 0, 0, 0, 3'd0, 1, 1));
        // Full with simultaneous pop: 0x00AA must be refused
        vecs.push_back(mk(1, 16'h0011, 0, 4'h5, 0,  1, 16'h0011, 4'h5, 0, 0, 0, 3'd1, 1, 1));
        vecs.push_back(mk(1, 16'h0012, 0, 4'h5, 0,  1, 16'h0011, 4'h5, 0, 0, 0, 3'd2, 1, 1));
        vecs.push_back(mk(1, 16'h0013, 0, 4'h5, 0,  1, 16'h0011, 4'h5, 0, 0, 0, 3'd3, 1, 1));
        vecs.push_back(mk(1, 16'h0014, 0, 4'h5, 0,  1, 16'h0011, 4'h5, 0, 0, 0, 3'd4, 0, 1));
        vecs.push_back(mk(1, 16'h00AA, 0, 4'h6, 1,  1, 16'h0012, 4'h5, 0, 0, 0, 3'd3, 1, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 4'h0, 1,  1, 16'h0013, 4'h5, 0, 0, 0, 3'd2, 1, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 4'h0, 1,  1, 16'h0014, 4'h5, 0, 0, 0, 3'd1, 1, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 4'h0, 1,  0, 16'h0000, 4'h0, 0, 0, 0, 3'd0, 1, 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_model();

        foreach (vecs[i]) begin
            apply_cycle(vecs[i].v, vecs[i].d, vecs[i].c, vecs[i].s, vecs[i].r);
            check($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_data",  i), 32'(bus.out_data),  32'(vecs[i].e_data));
            check($sformatf("v%0d_sel",   i), 32'(bus.out_sel),   32'(vecs[i].e_sel));
            check($sformatf("v%0d_carry", i), 32'(bus.out_carry), 32'(vecs[i].e_carry));
            check($sformatf("v%0d_zero",  i), 32'(bus.out_zero),  32'(vecs[i].e_zero));
            check($sformatf("v%0d_neg",   i), 32'(bus.out_neg),   32'(vecs[i].e_neg));
            check($sformatf("v%0d_count", i), 32'(bus.count),     32'(vecs[i].e_count));
            check($sformatf("v%0d_ready", i), 32'(bus.in_ready),  32'(vecs[i].e_ready));
            check($sformatf("v%0d_drop",  i), 32'(bus.drop_err),  32'(vecs[i].e_drop));
        end

        // Streaming across pointer wrap
        for (int i = 0; i < 10; i++) begin
            apply_cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 4'h8, 1'b1);
            check($sformatf("stream%0d_data", i), 32'(bus.out_data), 32'h0100 + 32'(i));
            check($sformatf("stream%0d_count", i), 32'(bus.count), 32'd1);
        end
        apply_cycle(1'b0, 16'h0000, 1'b0, 4'h0, 1'b1);
        check("stream_drained", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset with three entries buffered
        apply_cycle(1'b1, 16'h1111, 1'b0, 4'h1, 1'b0);
        apply_cycle(1'b1, 16'h2222, 1'b0, 4'h2, 1'b0);
        apply_cycle(1'b1, 16'h3333, 1'b0, 4'h3, 1'b0);
        check("pre_rst_count", 32'(bus.count), 32'd3);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        model_drop = 1'b0;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_count", 32'(bus.count), 32'd0);
        check("arst_drop",  32'(bus.drop_err), 32'd0);
        check("arst_data",  32'(bus.out_data), 32'd0);
        #1;
        rst_n = 1'b1;
        apply_cycle(1'b1, 16'hBEEF, 1'b1, 4'h7, 1'b0);
        check("post_rst_data", 32'(bus.out_data), 32'hBEEF);
        check("post_rst_neg",  32'(bus.out_neg), 32'd1);
        apply_cycle(1'b0, 16'h0000, 1'b0, 4'h0, 1'b1);

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] d;
            case ($urandom_range(0, 3))
                0:       d = 16'h0000;
                1:       d = 16'h8000 | 16'($urandom);
                default: d = 16'($urandom);
            endcase
            apply_cycle($urandom_range(0, 3) != 0, d, 1'($urandom), 4'($urandom),
                        1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the 16-bit combinational ALU. Captures each ALU result (ALU_Out, CarryOut, and the ALU_Sel that produced it) under a valid/ready handshake.
- At capture time it derives zero and negative flags.
- Entries are buffered in a small first-word-fall-through FIFO so that a slower consumer (display driver, register file write port) can drain results in order.

Parameters:
- DATA_W, 16, width of the ALU result path.
- SEL_W, 4, width of the ALU opcode tag stored with each result.
- DEPTH, 4, number of FIFO entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  the ALU output and tag are valid this cycle.
- in_ready  output  1  FIFO can accept an entry this cycle.
- alu_out  input  DATA_W  ALU result (ALU_Out).
- carry_out  input  1  ALU carry (CarryOut).
- alu_sel  input  SEL_W  opcode that produced alu_out.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts the head entry.
- out_data  output  DATA_W  head result.
- out_sel  output  SEL_W  head opcode tag.
- out_carry  output  1  head carry flag.
- out_zero  output  1  head zero flag (result == 0).
- out_neg  output  1  head negative flag (result MSB).
- count  output  clog2(DEPTH)+1  number of stored entries, from 0 to DEPTH.
- drop_err  output  1  sticky; in_valid seen while in_ready was low.

Behaviour:
- Reset (rst_n low, asynchronous): count=0, write pointer=0, read pointer=0, drop_err=0. Consequently out_valid=0 and in_ready=1. Storage array contents are not reset.
- in_ready = (count != DEPTH). It is combinational from count only and has no dependence on out_ready (no full-bypass).
- out_valid = (count != 0).
- When out_valid=0, out_data, out_sel, out_carry, out_zero and out_neg are forced to 0.
- Push occurs when in_valid && in_ready. The entry stored at the write pointer is {alu_out, alu_sel, carry_out, zero=(alu_out==0), neg=alu_out[DATA_W-1]}. The write pointer then increments modulo DEPTH.
- Pop occurs when out_valid && out_ready. The read pointer increments modulo DEPTH.
- Outputs always present the entry at the read pointer (first-word fall-through).
- Latency: a push on edge N makes out_valid=1 immediately after edge N. There is no same-cycle combinational pass-through from in_* to out_*.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Full and popping in the same cycle: in_ready=0, so no push occurs. count becomes DEPTH-1 and in_ready rises the next cycle.
- Empty and pushing: no pop is possible that cycle; the entry becomes visible next cycle.
- Pointer wrap: the pointers carry no extra wrap bit. count alone distinguishes full from empty.
- drop_err: set on any cycle with in_valid=1 and in_ready=0. It is cleared only by reset. The upstream is expected to hold its data, so this is a diagnostic only; FIFO state is unaffected.
- Flags are computed from the stored alu_out. They are not recomputed on output.
- Reset mid-operation: all buffered entries are discarded, and out_valid drops asynchronously with rst_n.
- No x-propagation: out_* must never show uninitialised storage because of the forcing to 0 when out_valid=0.

Test Plan:
- Single push/pop: push alu_out=0x0D78, carry=0, sel=0x1 with out_ready=0 → next cycle out_valid=1, out_data=0x0D78, out_zero=0, out_neg=0, count=1. Then set out_ready=1 → after 1 edge count=0, out_valid=0, out_data=0x0000.
- Flags: push 0x0000/carry=1/sel=0x2, then 0xF623/carry=0/sel=0x3 → entry 0 reads zero=1, carry=1. Entry 1 reads neg=1, zero=0, in push order.
- Fill and overflow: with out_ready=0, push 5 values 0x0001 through 0x0005 on consecutive cycles → count=4, in_ready=0 after the 4th push, 0x0005 not stored, drop_err=1. Drain order must be 0x0001..0x0004.
- Full with simultaneous pop: fill to 4, then assert in_valid (data 0x00AA) and out_ready together for 1 cycle → 0x00AA not accepted, count=3, in_ready=1 next cycle.
- Streaming wrap: hold in_valid=1 and out_ready=1 for 10 cycles with data 0x0100+i → count stays 1 after the first cycle. Outputs show 0x0100..0x0109 in order with no drops across pointer wrap.
- Asynchronous reset: with 3 entries stored, pulse rst_n low mid-cycle → out_valid=0, count=0, drop_err=0 without waiting for a clock edge. The next push is read back correctly.
